// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Arbitrates exception/ERET, memory-busy, taken-branch and load-use hazards; counts stall cycles.
module pipeline_ctrl #(
    parameter int REGADDR_WIDTH    = 5,
    parameter int EXC_FLUSH_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REGADDR_WIDTH-1:0] id_src1_addr,
    input  logic [REGADDR_WIDTH-1:0] id_src2_addr,
    input  logic                     id_src_valid,
    input  logic                     id_is_branch,
    input  logic                     ex_load_pending,
    input  logic [REGADDR_WIDTH-1:0] ex_wb_addr,
    input  logic                     ex_branch_taken,
    input  logic                     mem_busy,
    input  logic                     exc_req,
    input  logic                     eret_req,
    output logic                     stall_if,
    output logic                     stall_id,
    output logic                     stall_ex,
    output logic                     stall_mem,
    output logic                     clear_if,
    output logic                     clear_id,
    output logic                     clear_ex,
    output logic                     clear_mem,
    output logic [1:0]               pc_sel,
    output logic                     in_delay_slot,
    output logic [31:0]              stall_cycles
);
    localparam int CW = $clog2(EXC_FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    state_t        state, state_next;
    logic [CW-1:0] flush_cnt, flush_cnt_next;
    logic [31:0]   stall_cnt;
    logic          exc_any, load_use;

    assign exc_any  = exc_req | eret_req;
    assign load_use = ex_load_pending && ex_wb_addr != '0 && id_src_valid &&
                      (ex_wb_addr == id_src1_addr || ex_wb_addr == id_src2_addr);
    assign stall_cycles = stall_cnt;

    // MEM_WAIT with mem_busy low falls through to the normal RUN evaluation in the same cycle.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        {stall_if, stall_id, stall_ex, stall_mem} = 4'b0000;
        {clear_if, clear_id, clear_ex, clear_mem} = 4'b0000;
        pc_sel = 2'd0;
        if (rst) begin
            {clear_if, clear_id, clear_ex, clear_mem} = 4'b1111;
            state_next     = RUN;
            flush_cnt_next = '0;
        end else if (exc_any) begin
            {clear_if, clear_id, clear_ex, clear_mem} = 4'b1111;
            pc_sel         = exc_req ? 2'd2 : 2'd3;
            state_next     = EXC_FLUSH_CYCLES > 1 ? FLUSH : RUN;
            flush_cnt_next = CW'(EXC_FLUSH_CYCLES - 1);
        end else if (state == FLUSH) begin
            {clear_id, clear_ex} = 2'b11;
            flush_cnt_next = flush_cnt - 1'b1;
            state_next     = flush_cnt <= 1 ? RUN : FLUSH;
        end else if (mem_busy) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
            state_next = MEM_WAIT;
        end else begin
            state_next = RUN;
            if (ex_branch_taken) begin
                pc_sel   = 2'd1;
                clear_if = 1'b1;
            end else if (load_use) begin
                {stall_if, stall_id} = 2'b11;
                clear_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            flush_cnt     <= '0;
            in_delay_slot <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            state         <= state_next;
            flush_cnt     <= flush_cnt_next;
            in_delay_slot <= exc_any ? 1'b0 : stall_id ? in_delay_slot : id_is_branch & id_src_valid & ~clear_id;
            if (stall_if)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_pipeline_ctrl;
    localparam int EXC = 2;

    logic clk = 0, rst = 1;
    logic [4:0] id_src1_addr = 0, id_src2_addr = 0, ex_wb_addr = 0;
    logic id_src_valid = 0, id_is_branch = 0, ex_load_pending = 0, ex_branch_taken = 0;
    logic mem_busy = 0, exc_req = 0, eret_req = 0;
    logic stall_if, stall_id, stall_ex, stall_mem, clear_if, clear_id, clear_ex, clear_mem;
    logic [1:0] pc_sel;
    logic in_delay_slot;
    logic [31:0] stall_cycles;
    wire [9:0] outs = {stall_if, stall_id, stall_ex, stall_mem, clear_if, clear_id, clear_ex, clear_mem, pc_sel};

    int checks = 0, errors = 0;
    // model: mode 0 run, 1 waiting on memory, 2 flushing; m_left = flush cycles still to go
    int m_mode = 0, m_left = 0;
    logic m_ds = 0;
    logic [31:0] m_cnt = 0;

    pipeline_ctrl #(.REGADDR_WIDTH(5), .EXC_FLUSH_CYCLES(EXC)) dut (
        .clk(clk), .rst(rst), .id_src1_addr(id_src1_addr), .id_src2_addr(id_src2_addr),
        .id_src_valid(id_src_valid), .id_is_branch(id_is_branch), .ex_load_pending(ex_load_pending),
        .ex_wb_addr(ex_wb_addr), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .exc_req(exc_req), .eret_req(eret_req), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .stall_mem(stall_mem), .clear_if(clear_if), .clear_id(clear_id),
        .clear_ex(clear_ex), .clear_mem(clear_mem), .pc_sel(pc_sel), .in_delay_slot(in_delay_slot),
        .stall_cycles(stall_cycles));

    always #5 clk = ~clk;

    task automatic model(output logic [9:0] c, output int nm, output int nl, output logic nds);
        logic lu;
        lu = ex_load_pending && ex_wb_addr != 0 && id_src_valid &&
             (ex_wb_addr == id_src1_addr || ex_wb_addr == id_src2_addr);
        c = '0; nm = m_mode; nl = m_left; nds = m_ds;
        if (rst) begin
            c = 10'b0000_1111_00; nm = 0; nl = 0; nds = 0;
        end else if (exc_req || eret_req) begin
            c = {8'b0000_1111, exc_req ? 2'd2 : 2'd3};
            nl = EXC - 1; nm = nl > 0 ? 2 : 0; nds = 0;
        end else if (m_mode == 2) begin
            c = 10'b0000_0110_00; nl = m_left - 1; nm = nl == 0 ? 0 : 2; nds = 0;
        end else if (mem_busy) begin
            c = 10'b1111_0000_00; nm = 1;
        end else begin
            nm = 0;
            if (ex_branch_taken) c = 10'b0000_1000_01;
            else if (lu) c = 10'b1100_0010_00;
            nds = (lu && !ex_branch_taken) ? m_ds : (id_is_branch && id_src_valid);
        end
    endtask

    task automatic tick;
        logic [9:0] c; int nm, nl; logic nds;
        model(c, nm, nl, nds);
        @(posedge clk);
        m_mode = nm; m_left = nl; m_ds = nds;
        if (rst) m_cnt = 0; else if (c[9]) m_cnt = m_cnt + 1;
        @(negedge clk);
    endtask

    task automatic idle;
        {id_src_valid, id_is_branch, ex_load_pending, ex_branch_taken, mem_busy, exc_req, eret_req} = '0;
        id_src1_addr = 0; id_src2_addr = 0; ex_wb_addr = 0;
    endtask

    task automatic test_reset;
        rst = 1; idle();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1; ex_branch_taken = 1;
            #1; checks++;
            if (outs !== 10'b0000_1111_00) begin errors++; $display("FAIL reset_out cyc%0d got %b exp %b", i, outs, 10'b0000_1111_00); end
            tick();
        end
        rst = 0; idle(); #1;
        checks++;
        if ({in_delay_slot, stall_cycles} !== 33'd0) begin errors++; $display("FAIL reset_state ds=%b cnt=%0d exp 0/0", in_delay_slot, stall_cycles); end
        checks++;
        if (outs !== 10'd0) begin errors++; $display("FAIL reset_idle got %b exp 0", outs); end
    endtask

    task automatic test_load_use;
        logic [31:0] c0;
        ex_load_pending = 1; ex_wb_addr = 5; id_src2_addr = 5; id_src1_addr = 1; id_src_valid = 1;
        #1; c0 = stall_cycles; checks++;
        if (outs !== 10'b1100_0010_00) begin errors++; $display("FAIL load_use got %b exp %b", outs, 10'b1100_0010_00); end
        tick(); checks++;
        if (stall_cycles !== c0 + 1) begin errors++; $display("FAIL load_use_cnt got %0d exp %0d", stall_cycles, c0 + 1); end
        ex_wb_addr = 0; id_src2_addr = 0; #1; checks++;
        if (outs !== 10'd0) begin errors++; $display("FAIL load_r0 got %b exp 0", outs); end
        tick(); checks++;
        if (stall_cycles !== c0 + 1) begin errors++; $display("FAIL load_r0_cnt got %0d exp %0d", stall_cycles, c0 + 1); end
        idle();
    endtask

    task automatic test_mem_busy;
        logic [31:0] c0;
        c0 = stall_cycles;
        for (int i = 0; i < 4; i++) begin
            mem_busy = 1; #1; checks++;
            if (outs !== 10'b1111_0000_00) begin errors++; $display("FAIL mem_busy cyc%0d got %b exp %b", i, outs, 10'b1111_0000_00); end
            tick();
        end
        mem_busy = 0; #1; checks++;
        if (outs !== 10'd0 || stall_cycles !== c0 + 4) begin errors++; $display("FAIL mem_drop got %b cnt %0d exp 0 cnt %0d", outs, stall_cycles, c0 + 4); end
        tick();
        ex_branch_taken = 1; #1; checks++;
        if (outs !== 10'b0000_1000_01) begin errors++; $display("FAIL mem_back_run got %b exp %b", outs, 10'b0000_1000_01); end
        tick(); idle();
    endtask

    task automatic test_exception;
        exc_req = 1; #1; checks++;
        if (outs !== 10'b0000_1111_10) begin errors++; $display("FAIL exc_c0 got %b exp %b", outs, 10'b0000_1111_10); end
        tick(); exc_req = 0; mem_busy = 1; ex_branch_taken = 1; #1; checks++;
        if (outs !== 10'b0000_0110_00) begin errors++; $display("FAIL exc_c1 got %b exp %b", outs, 10'b0000_0110_00); end
        tick(); #1; checks++;
        if (outs !== 10'b1111_0000_00) begin errors++; $display("FAIL exc_c2_run got %b exp %b", outs, 10'b1111_0000_00); end
        idle(); tick();
        eret_req = 1; #1; checks++;
        if (outs !== 10'b0000_1111_11) begin errors++; $display("FAIL eret got %b exp %b", outs, 10'b0000_1111_11); end
        tick(); idle(); tick();
        exc_req = 1; eret_req = 1; mem_busy = 1; #1; checks++;
        if (outs !== 10'b0000_1111_10) begin errors++; $display("FAIL exc_mem got %b exp %b", outs, 10'b0000_1111_10); end
        tick(); idle(); tick();
    endtask

    task automatic test_delay_slot;
        id_is_branch = 1; id_src_valid = 1; tick();
        id_is_branch = 0; ex_load_pending = 1; ex_wb_addr = 7; id_src1_addr = 7; #1; checks++;
        if ({outs, in_delay_slot} !== 11'b1100_0010_00_1) begin errors++; $display("FAIL ds_stall got %b exp %b", {outs, in_delay_slot}, 11'b1100_0010_00_1); end
        tick(); #1; checks++;
        if (in_delay_slot !== 1'b1) begin errors++; $display("FAIL ds_hold got %b exp 1", in_delay_slot); end
        ex_branch_taken = 1; #1; checks++;
        if ({outs, in_delay_slot} !== 11'b0000_1000_01_1) begin errors++; $display("FAIL ds_branch got %b exp %b", {outs, in_delay_slot}, 11'b0000_1000_01_1); end
        tick(); checks++;
        if (in_delay_slot !== 1'b0) begin errors++; $display("FAIL ds_clear got %b exp 0", in_delay_slot); end
        idle();
    endtask

    task automatic test_wrap;
        idle(); #1;
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt;
        m_cnt = 32'hFFFF_FFFF;
        mem_busy = 1; tick(); #1; checks++;
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL wrap got %h exp 0", stall_cycles); end
        idle(); tick();
    endtask

    task automatic test_random;
        logic [9:0] c; int nm, nl; logic nds;
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(0, 99) == 0;
            exc_req = $urandom_range(0, 19) == 0;
            eret_req = $urandom_range(0, 19) == 0;
            mem_busy = $urandom_range(0, 4) == 0;
            ex_branch_taken = $urandom_range(0, 3) == 0;
            id_is_branch = $urandom_range(0, 2) == 0;
            id_src_valid = $urandom_range(0, 3) != 0;
            ex_load_pending = $urandom_range(0, 1) == 0;
            ex_wb_addr = 5'($urandom_range(0, 3));
            id_src1_addr = 5'($urandom_range(0, 3));
            id_src2_addr = 5'($urandom_range(0, 3));
            #1; model(c, nm, nl, nds); checks++;
            if ({outs, in_delay_slot, stall_cycles} !== {c, m_ds, m_cnt}) begin
                errors++;
                $display("FAIL rand cyc%0d got %b/%b/%0d exp %b/%b/%0d", i, outs, in_delay_slot, stall_cycles, c, m_ds, m_cnt);
            end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mem_busy();
        test_exception();
        test_delay_slot();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
